// File: rtl/xor_rr_scheduler_if.sv
// Bundle of the requester and result signals of xor_rr_scheduler.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high; the
// source holds valid and its payload stable until then, and ready may depend on valid.
interface xor_rr_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [ID_W-1:0]        out_id;
  logic                   out_ready;
  logic                   busy;

  modport master (
    output req_valid, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_data, out_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, out_ready,
    output req_ready, out_valid, out_data, out_id, busy
  );
endinterface

// File: rtl/xor_rr_scheduler.sv
// Round-robin scheduler sharing one registered XOR datapath between N_REQ requesters.
// Results come back on one valid/ready port tagged with the requester index.
module xor_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  xor_rr_scheduler_if.slave   bus,
  output logic                dbg_state,
  output logic [ID_W-1:0]     dbg_rr_ptr
);

  if ((2 ** ID_W) < N_REQ) begin : g_bad_id_w
    $error("xor_rr_scheduler: ID_W too narrow to tag N_REQ requesters");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("xor_rr_scheduler: N_REQ must be in 2..8");
  end

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic             can_accept;
  logic             found;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  ptr_after;
  logic [WIDTH-1:0] grant_data;
  int               scan_idx;

  // Scan from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    can_accept = (state_q == S_EMPTY) || bus.out_ready;
    found      = 1'b0;
    grant      = '0;
    grant_idx  = '0;
    ptr_after  = '0;
    grant_data = '0;
    scan_idx   = 0;
    if (!rst && can_accept) begin
      for (int k = 0; k < N_REQ; k++) begin
        scan_idx = int'(rr_ptr_q) + k;
        if (scan_idx >= N_REQ) begin
          scan_idx = scan_idx - N_REQ;
        end
        if (!found && bus.req_valid[scan_idx]) begin
          found           = 1'b1;
          grant[scan_idx] = 1'b1;
          grant_idx       = ID_W'(scan_idx);
          ptr_after       = ID_W'((scan_idx + 1) % N_REQ);
          grant_data      = bus.req_a[scan_idx*WIDTH +: WIDTH] ^ bus.req_b[scan_idx*WIDTH +: WIDTH];
        end
      end
    end
  end

  // A grant may coincide with a drain: the new result overwrites the one being taken.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    if (found) begin
      state_d  = S_FULL;
      data_d   = grant_data;
      id_d     = grant_idx;
      rr_ptr_d = ptr_after;
    end else if (state_q == S_FULL && bus.out_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_EMPTY;
      data_q   <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.out_valid = (state_q == S_FULL);
  assign bus.busy      = (state_q == S_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;
  assign dbg_state     = (state_q == S_FULL);
  assign dbg_rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_xor_rr_scheduler.sv
// Bench for xor_rr_scheduler: directed vector table, then randomized traffic against a
// round-robin reference model with a result scoreboard and a fairness monitor.
module tb_xor_rr_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic dbg_state;
  logic [IW-1:0] dbg_rr_ptr;

  always #5 clk = ~clk;

  xor_rr_scheduler_if #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();

  xor_rr_scheduler #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  // reference model state
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_id;
  int           m_ptr;
  int           last_g;
  logic [N-1:0] seen_rdy;

  logic [IW+W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pick the valid requester at the smallest circular distance ahead of the pointer.
  function automatic int model_pick(input logic [N-1:0] v, input int ptr);
    int best;
    int best_d;
    int d;
    best   = -1;
    best_d = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        d = (i - ptr + N) % N;
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    return best;
  endfunction

  // One clock: compare at negedge, then advance the model at the rising edge.
  task automatic step();
    int g;
    logic [W-1:0] xd;
    logic [IW+W-1:0] item;
    @(negedge clk);
    if (rst || (m_valid && !bus.out_ready)) g = -1;
    else g = model_pick(bus.req_valid, m_ptr);
    seen_rdy = bus.req_ready;
    check("req_ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("busy", 32'(bus.busy), 32'(m_valid));
    check("out_data", 32'(bus.out_data), 32'(m_data));
    check("out_id", 32'(bus.out_id), 32'(m_id));
    check("rr_ptr", 32'(dbg_rr_ptr), 32'(m_ptr));
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", 32'(bus.out_data), 32'hDEAD);
      end else begin
        item = exp_q.pop_front();
        check("sb_result", 32'({bus.out_id, bus.out_data}), 32'(item));
      end
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_id    = 0;
      m_ptr   = 0;
      exp_q.delete();
    end else if (g >= 0) begin
      xd      = W'((bus.req_a >> (g * W)) ^ (bus.req_b >> (g * W)));
      m_valid = 1'b1;
      m_data  = xd;
      m_id    = g;
      m_ptr   = (g + 1) % N;
      exp_q.push_back({IW'(g), xd});
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0;
    end
    last_g = g;
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         rst;
    logic [N-1:0] vld;
    logic [31:0]  a;
    logic [31:0]  b;
    logic         ordy;
    logic [N-1:0] exp_rdy;
    logic         exp_ov;
    logic [W-1:0] exp_od;
    logic [IW-1:0] exp_oid;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [N-1:0] v, input logic [31:0] a,
                     input logic [31:0] b, input logic o, input logic [N-1:0] er,
                     input logic eov, input logic [W-1:0] eod, input logic [IW-1:0] eid);
    vec_t e;
    e.rst = r; e.vld = v; e.a = a; e.b = b; e.ordy = o;
    e.exp_rdy = er; e.exp_ov = eov; e.exp_od = eod; e.exp_oid = eid;
    tbl.push_back(e);
  endtask

  localparam logic [31:0] A_IDX = 32'h03020100;
  localparam logic [31:0] B_FF  = 32'hFFFFFFFF;

  // ---------------- random phase state ----------------
  logic [N-1:0] pend;
  int           waits[N];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0; last_g = -1;
    rst = 1'b1;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // reset held two cycles, then a single request
    add(1, 4'b0000, 32'h0,        32'h0,        1, 4'b0000, 0, 8'h00, 2'd0);
    add(1, 4'b0000, 32'h0,        32'h0,        1, 4'b0000, 0, 8'h00, 2'd0);
    add(0, 4'b0001, 32'h000000F0, 32'h0000003C, 1, 4'b0001, 1, 8'hCC, 2'd0);
    // all four requesting back to back from pointer 0
    add(1, 4'b1111, A_IDX, B_FF, 1, 4'b0000, 0, 8'h00, 2'd0);
    add(0, 4'b1111, A_IDX, B_FF, 1, 4'b0001, 1, 8'hFF, 2'd0);
    add(0, 4'b1111, A_IDX, B_FF, 1, 4'b0010, 1, 8'hFE, 2'd1);
    add(0, 4'b1111, A_IDX, B_FF, 1, 4'b0100, 1, 8'hFD, 2'd2);
    add(0, 4'b1111, A_IDX, B_FF, 1, 4'b1000, 1, 8'hFC, 2'd3);
    add(0, 4'b1111, A_IDX, B_FF, 1, 4'b0001, 1, 8'hFF, 2'd0);
    // load 0x55, then three cycles of backpressure, then resume
    add(0, 4'b0010, 32'h00005500, 32'h0, 1, 4'b0010, 1, 8'h55, 2'd1);
    add(0, 4'b1111, A_IDX, B_FF, 0, 4'b0000, 1, 8'h55, 2'd1);
    add(0, 4'b1111, A_IDX, B_FF, 0, 4'b0000, 1, 8'h55, 2'd1);
    add(0, 4'b1111, A_IDX, B_FF, 0, 4'b0000, 1, 8'h55, 2'd1);
    add(0, 4'b1111, A_IDX, B_FF, 1, 4'b0100, 1, 8'hFD, 2'd2);
    // steer pointer to 2, then wrap-around with 0011
    add(0, 4'b1000, A_IDX, B_FF, 1, 4'b1000, 1, 8'hFC, 2'd3);
    add(0, 4'b0010, A_IDX, B_FF, 1, 4'b0010, 1, 8'hFE, 2'd1);
    add(0, 4'b0011, A_IDX, B_FF, 1, 4'b0001, 1, 8'hFF, 2'd0);
    add(0, 4'b0011, A_IDX, B_FF, 1, 4'b0010, 1, 8'hFE, 2'd1);
    // drain with nothing new
    add(0, 4'b0000, A_IDX, B_FF, 1, 4'b0000, 0, 8'hFE, 2'd1);
    // reset while holding a result with pointer at 3
    add(0, 4'b0100, A_IDX, B_FF, 1, 4'b0100, 1, 8'hFD, 2'd2);
    add(1, 4'b1111, A_IDX, B_FF, 0, 4'b0000, 0, 8'h00, 2'd0);
    add(0, 4'b1111, A_IDX, B_FF, 1, 4'b0001, 1, 8'hFF, 2'd0);

    foreach (tbl[i]) begin
      rst           = tbl[i].rst;
      bus.req_valid = tbl[i].vld;
      bus.req_a     = tbl[i].a;
      bus.req_b     = tbl[i].b;
      bus.out_ready = tbl[i].ordy;
      step();
      check($sformatf("vec%0d_ready", i), 32'(seen_rdy), 32'(tbl[i].exp_rdy));
      check($sformatf("vec%0d_ov", i), 32'(bus.out_valid), 32'(tbl[i].exp_ov));
      check($sformatf("vec%0d_od", i), 32'(bus.out_data), 32'(tbl[i].exp_od));
      check($sformatf("vec%0d_oid", i), 32'(bus.out_id), 32'(tbl[i].exp_oid));
    end

    // hand sequence: grant and drain in the same cycle keeps out_valid high
    rst = 1'b0; bus.req_valid = 4'b0100; bus.out_ready = 1'b1;
    step();
    check("bb_valid", 32'(bus.out_valid), 32'd1);
    check("bb_data", 32'(bus.out_data), 32'hFD);
    check("bb_id", 32'(bus.out_id), 32'd2);

    // ---------------- randomized traffic ----------------
    pend = '0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    bus.req_valid = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 45) begin
          pend[i] = 1'b1;
          bus.req_a[i*W +: W] = W'($urandom);
          bus.req_b[i*W +: W] = W'($urandom);
        end
      end
      bus.req_valid = pend;
      bus.out_ready = ($urandom_range(0, 99) < 70);
      rst           = ($urandom_range(0, 199) == 0);
      step();
      if (last_g >= 0) begin
        checks++;
        if (waits[last_g] >= N) begin
          errors++;
          $display("FAIL fairness: requester %0d waited %0d grants, limit %0d", last_g, waits[last_g], N - 1);
        end
        for (int i = 0; i < N; i++) begin
          if (pend[i] && i != last_g) waits[i]++;
        end
        pend[last_g]  = 1'b0;
        waits[last_g] = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_rr_scheduler.md
Name: xor_rr_scheduler

Overview:
- Shares one registered WIDTH-bit XOR datapath between N_REQ requesters.
- Arbitration is round-robin. Each requester has a valid/ready port.
- Results are returned on a single valid/ready output, tagged with the requester index.
- Sits between multiple client blocks and the common XOR resource, so no client needs its own gate array.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand and result width in bits.
- ID_W, 2, width of the requester tag; 2**ID_W >= N_REQ is required.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  bit i high = requester i presents an operand pair.
- req_a  input  N_REQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  N_REQ*WIDTH  operand B, same slicing as req_a.
- req_ready  output  N_REQ  one-hot grant; bit i high = requester i's pair is consumed this cycle.
- out_valid  output  1  result register holds a valid result.
- out_data  output  WIDTH  A XOR B of the granted pair.
- out_id  output  ID_W  index of the requester that produced out_data.
- out_ready  input  1  consumer accepts the result this cycle.
- busy  output  1  equals out_valid; provided for status polling.

Behaviour:
- Reset (rst=1 at a rising edge): out_valid=0, out_data=0, out_id=0, rr_ptr=0. req_ready is 0 during any cycle in which rst is high. Reset mid-operation discards a held result without handshake.
- Output register state machine:
  - EMPTY (out_valid=0): any valid request is granted.
  - FULL (out_valid=1):
    - out_ready=1 → the result is drained and a new grant is allowed in the same cycle (back-to-back throughput of 1 result per cycle).
    - out_ready=0 → no grant; all req_ready bits are 0 and out_data/out_id are held stable.
- can_accept = !out_valid | out_ready. req_ready is combinational from req_valid, rr_ptr and can_accept.
- Arbitration:
  - Among requesters with req_valid=1, grant the first index found when searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - At most one req_ready bit is high per cycle.
  - req_ready[i] is never high while req_valid[i]=0.
- On a grant to index g at edge k:
  - out_data <= a[g] ^ b[g]; out_id <= g; out_valid <= 1; rr_ptr <= (g+1) mod N_REQ.
  - Latency is 1 cycle: the result is visible after edge k.
- Drain without a new grant: out_valid <= 0; out_data and out_id keep their last values.
- No valid requests and no drain: all registers hold. rr_ptr changes only on a grant.
- Fairness: a continuously asserted request is granted within N_REQ grants.
- Requesters must hold req_valid and their operands stable until req_ready. The scheduler does not check this.
- Simultaneous drain and grant:
  - out_valid stays 1 and the new result replaces the old one at the same edge.
  - The consumer has taken the old value in that cycle.
- Invalid parameter combination (2**ID_W < N_REQ): elaboration-time error.

Test Plan:
1. Reset then single request: rst held 2 cycles, then req_valid=0001, a0=8'hF0, b0=8'h3C, out_ready=1. Required: req_ready=0001 in that cycle; next cycle out_valid=1, out_data=8'hCC, out_id=0; rr_ptr becomes 1.
2. All four requesting continuously, out_ready=1, a[i]=i, b[i]=8'hFF. Required grant order 0,1,2,3,0,... one per cycle; out_data sequence FF,FE,FD,FC; each out_id matches the requester.
3. Backpressure: out_valid=1 with out_data=8'h55, then out_ready=0 for 3 cycles while req_valid=1111. Required: req_ready=0000 and out_data/out_id unchanged for those 3 cycles; grant resumes in the cycle out_ready returns to 1.
4. Pointer skip: rr_ptr=2, req_valid=0011. Required: grant to requester 0 (wrap-around); rr_ptr becomes 1; the next cycle with 0011 still asserted grants requester 1.
5. Drain with no new request: out_valid=1, out_ready=1, req_valid=0000. Required: out_valid=0 next cycle; out_data unchanged; busy=0.
6. Reset mid-operation: out_valid=1, rr_ptr=3, rst asserted one cycle with req_valid=1111. Required: req_ready=0000 during reset; afterwards out_valid=0, out_id=0, and the first grant goes to requester 0.
